// File: rtl/pkt_stat_cnt.sv
// Per-port packet statistics: framing FSM, packet/word/error counters with sticky overflow,
// snapshot shadow bank with registered read port, and a live all-port packet total.
module pkt_stat_cnt #(
  parameter int unsigned PORT_NUB_TOTAL = 16,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TOTAL_WIDTH    = 20,
  parameter bit          SATURATE       = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORT_NUB_TOTAL-1:0]         wr_sop,
  input  logic [PORT_NUB_TOTAL-1:0]         wr_eop,
  input  logic [PORT_NUB_TOTAL-1:0]         wr_vld,
  input  logic                              clr,
  input  logic                              snap,
  input  logic [$clog2(PORT_NUB_TOTAL)-1:0] rd_sel,
  output logic [CNT_WIDTH-1:0]              rd_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              rd_word_cnt,
  output logic [CNT_WIDTH-1:0]              rd_err_cnt,
  output logic                              rd_ovf,
  output logic [TOTAL_WIDTH-1:0]            total_pkt_cnt,
  output logic [PORT_NUB_TOTAL-1:0]         in_pkt
);

  localparam int unsigned SelW    = $clog2(PORT_NUB_TOTAL);
  localparam int unsigned SelChkW = SelW + 1;
  localparam int unsigned PopW    = $clog2(PORT_NUB_TOTAL + 1);
  localparam int unsigned SumW    = TOTAL_WIDTH + 1;

  typedef enum logic {StIdle, StInPkt} state_e;

  state_e state_q [PORT_NUB_TOTAL];
  state_e state_d [PORT_NUB_TOTAL];

  logic [PORT_NUB_TOTAL-1:0] sop_q;
  logic [PORT_NUB_TOTAL-1:0] sop_rise;
  logic [PORT_NUB_TOTAL-1:0] pkt_inc;
  logic [PORT_NUB_TOTAL-1:0] err_inc;

  logic [CNT_WIDTH-1:0] pkt_q  [PORT_NUB_TOTAL];
  logic [CNT_WIDTH-1:0] pkt_d  [PORT_NUB_TOTAL];
  logic [CNT_WIDTH-1:0] word_q [PORT_NUB_TOTAL];
  logic [CNT_WIDTH-1:0] word_d [PORT_NUB_TOTAL];
  logic [CNT_WIDTH-1:0] err_q  [PORT_NUB_TOTAL];
  logic [CNT_WIDTH-1:0] err_d  [PORT_NUB_TOTAL];
  logic [PORT_NUB_TOTAL-1:0] ovf_q;
  logic [PORT_NUB_TOTAL-1:0] ovf_d;

  logic [CNT_WIDTH-1:0] sh_pkt_q  [PORT_NUB_TOTAL];
  logic [CNT_WIDTH-1:0] sh_word_q [PORT_NUB_TOTAL];
  logic [CNT_WIDTH-1:0] sh_err_q  [PORT_NUB_TOTAL];
  logic [PORT_NUB_TOTAL-1:0] sh_ovf_q;

  logic [PopW-1:0]        pop;
  logic [SumW-1:0]        total_sum;
  logic [TOTAL_WIDTH-1:0] total_q;
  logic [TOTAL_WIDTH-1:0] total_d;

  logic                 rd_in_range;
  logic [CNT_WIDTH-1:0] rd_pkt_d;
  logic [CNT_WIDTH-1:0] rd_word_d;
  logic [CNT_WIDTH-1:0] rd_err_d;
  logic                 rd_ovf_d;

  // A held-high sop counts once: only its rising edge starts a packet.
  assign sop_rise = wr_sop & ~sop_q;

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v, input logic inc);
    if (!inc) return v;
    if (&v) return SATURATE ? v : '0;
    return v + CNT_WIDTH'(1);
  endfunction

  // Framing FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      sop_q <= '0;
      for (int p = 0; p < PORT_NUB_TOTAL; p++) state_q[p] <= StIdle;
    end else begin
      sop_q <= wr_sop;
      for (int p = 0; p < PORT_NUB_TOTAL; p++) state_q[p] <= state_d[p];
    end
  end

  // Framing FSM: next state
  always_comb begin
    for (int p = 0; p < PORT_NUB_TOTAL; p++) begin
      state_d[p] = state_q[p];
      unique case (state_q[p])
        StIdle:  if (sop_rise[p] && !wr_eop[p]) state_d[p] = StInPkt;
        StInPkt: if (wr_eop[p]) state_d[p] = StIdle;
      endcase
    end
  end

  // Framing FSM: outputs and event strobes
  always_comb begin
    pkt_inc = sop_rise;
    err_inc = '0;
    in_pkt  = '0;
    for (int p = 0; p < PORT_NUB_TOTAL; p++) begin
      if (state_q[p] == StInPkt) begin
        in_pkt[p]  = 1'b1;
        err_inc[p] = sop_rise[p];
      end else begin
        err_inc[p] = wr_eop[p] & ~sop_rise[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PORT_NUB_TOTAL; p++) begin
      pkt_d[p]  = bump(pkt_q[p], pkt_inc[p]);
      word_d[p] = bump(word_q[p], wr_vld[p]);
      err_d[p]  = bump(err_q[p], err_inc[p]);
      ovf_d[p]  = ovf_q[p] | (pkt_inc[p] & (&pkt_q[p])) | (wr_vld[p] & (&word_q[p]))
                  | (err_inc[p] & (&err_q[p]));
      if (clr) begin
        pkt_d[p]  = '0;
        word_d[p] = '0;
        err_d[p]  = '0;
        ovf_d[p]  = 1'b0;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int p = 0; p < PORT_NUB_TOTAL; p++) pop = pop + PopW'(pkt_inc[p]);
    total_sum = {1'b0, total_q} + SumW'(pop);
    if (total_sum[TOTAL_WIDTH]) begin
      total_d = SATURATE ? '1 : total_sum[TOTAL_WIDTH-1:0];
    end else begin
      total_d = total_sum[TOTAL_WIDTH-1:0];
    end
    if (clr) total_d = '0;
  end

  // Unused codes of rd_sel read as zero when the port count is not a power of two.
  always_comb begin
    rd_in_range = ({1'b0, rd_sel} < SelChkW'(PORT_NUB_TOTAL));
    rd_pkt_d    = '0;
    rd_word_d   = '0;
    rd_err_d    = '0;
    rd_ovf_d    = 1'b0;
    if (rd_in_range) begin
      rd_pkt_d  = sh_pkt_q[rd_sel];
      rd_word_d = sh_word_q[rd_sel];
      rd_err_d  = sh_err_q[rd_sel];
      rd_ovf_d  = sh_ovf_q[rd_sel];
    end
  end

  // Shadows take the pre-update live values, so snap+clr together loses nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PORT_NUB_TOTAL; p++) begin
        pkt_q[p]     <= '0;
        word_q[p]    <= '0;
        err_q[p]     <= '0;
        sh_pkt_q[p]  <= '0;
        sh_word_q[p] <= '0;
        sh_err_q[p]  <= '0;
      end
      ovf_q       <= '0;
      sh_ovf_q    <= '0;
      total_q     <= '0;
      rd_pkt_cnt  <= '0;
      rd_word_cnt <= '0;
      rd_err_cnt  <= '0;
      rd_ovf      <= 1'b0;
    end else begin
      for (int p = 0; p < PORT_NUB_TOTAL; p++) begin
        pkt_q[p]  <= pkt_d[p];
        word_q[p] <= word_d[p];
        err_q[p]  <= err_d[p];
        if (snap) begin
          sh_pkt_q[p]  <= pkt_q[p];
          sh_word_q[p] <= word_q[p];
          sh_err_q[p]  <= err_q[p];
        end
      end
      ovf_q   <= ovf_d;
      total_q <= total_d;
      if (snap) sh_ovf_q <= ovf_q;
      rd_pkt_cnt  <= rd_pkt_d;
      rd_word_cnt <= rd_word_d;
      rd_err_cnt  <= rd_err_d;
      rd_ovf      <= rd_ovf_d;
    end
  end

  assign total_pkt_cnt = total_q;

endmodule

// File: tb/tb_pkt_stat_cnt.sv
// Directed bench for pkt_stat_cnt: a default instance plus two 4-bit-counter instances
// (saturating and wrapping) sharing the same stimulus.
module tb_pkt_stat_cnt;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wr_sop, wr_eop, wr_vld;
  logic        clr, snap;
  logic [3:0]  rd_sel;

  logic [15:0] rd_pkt_cnt, rd_word_cnt, rd_err_cnt;
  logic        rd_ovf;
  logic [19:0] total_pkt_cnt;
  logic [15:0] in_pkt;

  logic [3:0]  s_pkt, s_word, s_err;
  logic        s_ovf;
  logic [19:0] s_total;
  logic [15:0] s_in_pkt;

  logic [3:0]  w_pkt, w_word, w_err;
  logic        w_ovf;
  logic [19:0] w_total;
  logic [15:0] w_in_pkt;

  int n_checks = 0;
  int n_err    = 0;
  int hi_cnt;
  logic seen3;

  always #5 clk = ~clk;

  pkt_stat_cnt u_dut (
    .clk(clk), .rst(rst), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
    .clr(clr), .snap(snap), .rd_sel(rd_sel), .rd_pkt_cnt(rd_pkt_cnt),
    .rd_word_cnt(rd_word_cnt), .rd_err_cnt(rd_err_cnt), .rd_ovf(rd_ovf),
    .total_pkt_cnt(total_pkt_cnt), .in_pkt(in_pkt)
  );

  pkt_stat_cnt #(.CNT_WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
    .clr(clr), .snap(snap), .rd_sel(rd_sel), .rd_pkt_cnt(s_pkt),
    .rd_word_cnt(s_word), .rd_err_cnt(s_err), .rd_ovf(s_ovf),
    .total_pkt_cnt(s_total), .in_pkt(s_in_pkt)
  );

  pkt_stat_cnt #(.CNT_WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
    .clr(clr), .snap(snap), .rd_sel(rd_sel), .rd_pkt_cnt(w_pkt),
    .rd_word_cnt(w_word), .rd_err_cnt(w_err), .rd_ovf(w_ovf),
    .total_pkt_cnt(w_total), .in_pkt(w_in_pkt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs set before a step are sampled at its edge; outputs read after it reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_sop = '0; wr_eop = '0; wr_vld = '0; clr = 1'b0; snap = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1; step(); snap = 1'b0;
  endtask

  task automatic rd_port(input logic [3:0] p);
    rd_sel = p; step();
  endtask

  // Single-word packet on the ports in mask, followed by a quiet cycle.
  task automatic one_word_pkt(input logic [15:0] mask);
    wr_sop = mask; wr_eop = mask; step();
    wr_sop = '0; wr_eop = '0; step();
  endtask

  initial begin
    idle_inputs();
    rd_sel = '0;
    rst = 1'b1;
    step(); step();
    chk("reset_total", 32'(total_pkt_cnt), 0);
    chk("reset_in_pkt", 32'(in_pkt), 0);
    chk("reset_rd_pkt", 32'(rd_pkt_cnt), 0);
    chk("reset_rd_ovf", 32'(rd_ovf), 0);
    rst = 1'b0;
    step();

    // Basic packet on port 0: 10 words over 10 cycles.
    hi_cnt = 0;
    wr_sop = 16'h0001; wr_vld = 16'h0001; step();
    if (in_pkt[0]) hi_cnt++;
    wr_sop = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (in_pkt[0]) hi_cnt++;
    end
    wr_eop = 16'h0001; step();
    if (in_pkt[0]) hi_cnt++;
    idle_inputs();
    chk("basic_in_pkt_cycles", 32'(hi_cnt), 9);
    chk("basic_in_pkt_end", 32'(in_pkt[0]), 0);
    chk("basic_total", 32'(total_pkt_cnt), 1);
    do_snap();
    rd_port(4'd0);
    chk("basic_pkt", 32'(rd_pkt_cnt), 1);
    chk("basic_word", 32'(rd_word_cnt), 10);
    chk("basic_err", 32'(rd_err_cnt), 0);
    chk("basic_ovf", 32'(rd_ovf), 0);

    // All 16 ports start together three times.
    do_clr();
    chk("clr_total", 32'(total_pkt_cnt), 0);
    for (int r = 1; r <= 3; r++) begin
      one_word_pkt(16'hFFFF);
      chk("all_total_round", 32'(total_pkt_cnt), 32'(16 * r));
    end
    do_snap();
    rd_port(4'd0);
    chk("all_pkt_p0", 32'(rd_pkt_cnt), 3);
    rd_port(4'd7);
    chk("all_pkt_p7", 32'(rd_pkt_cnt), 3);
    rd_port(4'd15);
    chk("all_pkt_p15", 32'(rd_pkt_cnt), 3);
    chk("all_err_p15", 32'(rd_err_cnt), 0);

    // Framing errors on port 2; single-word packet on port 3.
    do_clr();
    seen3 = 1'b0;
    wr_sop = 16'h000C; wr_eop = 16'h0008; step();
    seen3 |= in_pkt[3];
    chk("frm_p2_in_pkt", 32'(in_pkt[2]), 1);
    idle_inputs(); step();
    seen3 |= in_pkt[3];
    wr_sop = 16'h0004; step();
    seen3 |= in_pkt[3];
    chk("frm_p2_still_in", 32'(in_pkt[2]), 1);
    idle_inputs(); step();
    wr_eop = 16'h0004; step();
    seen3 |= in_pkt[3];
    chk("frm_p2_closed", 32'(in_pkt[2]), 0);
    idle_inputs(); step();
    wr_eop = 16'h0004; step();
    seen3 |= in_pkt[3];
    idle_inputs();
    chk("frm_p2_idle", 32'(in_pkt[2]), 0);
    chk("frm_p3_never_in", 32'(seen3), 0);
    chk("frm_total", 32'(total_pkt_cnt), 3);
    do_snap();
    rd_port(4'd2);
    chk("frm_p2_pkt", 32'(rd_pkt_cnt), 2);
    chk("frm_p2_err", 32'(rd_err_cnt), 2);
    rd_port(4'd3);
    chk("frm_p3_pkt", 32'(rd_pkt_cnt), 1);
    chk("frm_p3_err", 32'(rd_err_cnt), 0);

    // Overflow with 4-bit counters: 20 packets on port 1.
    do_clr();
    for (int i = 0; i < 20; i++) one_word_pkt(16'h0002);
    do_snap();
    rd_port(4'd1);
    chk("ovf_sat_pkt", 32'(s_pkt), 15);
    chk("ovf_sat_flag", 32'(s_ovf), 1);
    chk("ovf_wrap_pkt", 32'(w_pkt), 4);
    chk("ovf_wrap_flag", 32'(w_ovf), 1);
    chk("ovf_wide_pkt", 32'(rd_pkt_cnt), 20);
    chk("ovf_wide_flag", 32'(rd_ovf), 0);
    chk("ovf_total", 32'(total_pkt_cnt), 20);
    do_clr();
    do_snap();
    rd_port(4'd1);
    chk("ovf_clr_sat_pkt", 32'(s_pkt), 0);
    chk("ovf_clr_sat_flag", 32'(s_ovf), 0);
    chk("ovf_clr_wrap_pkt", 32'(w_pkt), 0);
    chk("ovf_clr_wrap_flag", 32'(w_ovf), 0);

    // snap and clr together while port 5 starts a new packet.
    for (int i = 0; i < 7; i++) one_word_pkt(16'h0020);
    snap = 1'b1; clr = 1'b1; wr_sop = 16'h0020; step();
    idle_inputs();
    chk("col_in_pkt", 32'(in_pkt[5]), 1);
    chk("col_total", 32'(total_pkt_cnt), 0);
    rd_port(4'd5);
    chk("col_shadow_pkt", 32'(rd_pkt_cnt), 7);
    do_snap();
    rd_port(4'd5);
    chk("col_live_pkt", 32'(rd_pkt_cnt), 0);
    wr_eop = 16'h0020; step();
    idle_inputs();
    chk("col_closed", 32'(in_pkt[5]), 0);

    // Sop held high for 50 cycles on port 6 counts once.
    do_clr();
    wr_sop = 16'h0040;
    for (int i = 0; i < 50; i++) step();
    chk("sticky_in_pkt", 32'(in_pkt[6]), 1);
    wr_sop = '0; wr_eop = 16'h0040; step();
    idle_inputs(); step();
    chk("sticky_total", 32'(total_pkt_cnt), 1);
    do_snap();
    rd_port(4'd6);
    chk("sticky_pkt", 32'(rd_pkt_cnt), 1);
    chk("sticky_err", 32'(rd_err_cnt), 0);

    // Reset 25 cycles into a packet, then a clean packet.
    wr_sop = 16'h0040; wr_vld = 16'h0040; step();
    wr_sop = '0;
    for (int i = 0; i < 24; i++) step();
    idle_inputs();
    rst = 1'b1; step();
    rst = 1'b0;
    chk("rst_in_pkt", 32'(in_pkt), 0);
    chk("rst_total", 32'(total_pkt_cnt), 0);
    wr_sop = 16'h0040; wr_vld = 16'h0040; step();
    chk("rst_new_in_pkt", 32'(in_pkt[6]), 1);
    wr_sop = '0; wr_eop = 16'h0040; step();
    idle_inputs(); step();
    do_snap();
    rd_port(4'd6);
    chk("rst_pkt", 32'(rd_pkt_cnt), 1);
    chk("rst_err", 32'(rd_err_cnt), 0);
    chk("rst_word", 32'(rd_word_cnt), 2);
    chk("rst_total_after", 32'(total_pkt_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_stat_cnt.md
# pkt_stat_cnt

Per-port packet statistics block for the N×N switch: replaces the bench-only single packet counter with a parametrised, synthesizable counter bank. It sits alongside the write (or read) side of `top_nxn` and gives a register-read view of counts per port, plus a live total. It tracks framing per port and counts packets, valid words and framing errors, with selectable saturate or wrap behaviour, snapshot and clear.

## Interface
Parameters:
- `PORT_NUB_TOTAL`, default 16: number of ports, ≥2.
- `CNT_WIDTH`, default 16: width of each per-port counter.
- `TOTAL_WIDTH`, default 20: width of the total packet counter.
- `SATURATE`, default 1: 1 = counters hold at all-ones; 0 = counters wrap to 0.

Ports:
- `clk`, input, 1: single clock for all logic.
- `rst`, input, 1: synchronous, active-high reset.
- `wr_sop`, input, PORT_NUB_TOTAL: per-port start of packet.
- `wr_eop`, input, PORT_NUB_TOTAL: per-port end of packet.
- `wr_vld`, input, PORT_NUB_TOTAL: per-port word valid.
- `clr`, input, 1: clears all counters and overflow flags.
- `snap`, input, 1: copies all live per-port counters into shadow registers.
- `rd_sel`, input, $clog2(PORT_NUB_TOTAL): port whose shadow values are read.
- `rd_pkt_cnt`, output, CNT_WIDTH: shadow packet count of the selected port.
- `rd_word_cnt`, output, CNT_WIDTH: shadow word count of the selected port.
- `rd_err_cnt`, output, CNT_WIDTH: shadow framing-error count of the selected port.
- `rd_ovf`, output, 1: shadow sticky overflow flag of the selected port (set if any of its counters overflowed).
- `total_pkt_cnt`, output, TOTAL_WIDTH: live count of packets summed over all ports.
- `in_pkt`, output, PORT_NUB_TOTAL: per-port framing state, 1 = IN_PKT.

## Operation
- Each port registers `wr_sop` as `sop_d`. A packet start is `sop_rise = wr_sop & ~sop_d`; a held-high `wr_sop` counts once.
- Each port has a two-state framing FSM, IDLE or IN_PKT. `in_pkt` reflects the state.
  - IDLE, sop_rise and no eop: pkt +1, go to IN_PKT.
  - IDLE, sop_rise and eop in the same cycle (single-word packet): pkt +1, stay IDLE.
  - IDLE, eop without sop_rise: err +1, stay IDLE.
  - IN_PKT, eop without sop_rise: go to IDLE.
  - IN_PKT, sop_rise (missing eop): err +1, pkt +1. If eop is in the same cycle, go to IDLE; otherwise stay IN_PKT.
- `word_cnt` adds 1 for every cycle its port's `wr_vld` = 1, in either state.
- Total: `total_pkt_cnt` adds, each cycle, the population count of the per-port pkt-increment strobes. Adder width is $clog2(PORT_NUB_TOTAL+1), so all ports starting in one cycle must add exactly PORT_NUB_TOTAL.
- Overflow, SATURATE=1: a counter at all-ones stays at all-ones, and its port's `ovf` is set.
- Overflow, SATURATE=0: a counter at all-ones goes to 0, and its port's `ovf` is set.
- Overflow of `total_pkt_cnt` follows the same SATURATE rule but has no flag.
- `ovf` is sticky; only `clr` or `rst` clears it.
- `clr`: all live counters, `ovf` flags and `total_pkt_cnt` become 0 next cycle. Any increment in the `clr` cycle is discarded. FSM states, `sop_d` and shadow registers are unaffected.
- `snap`: shadow = live value as it was at the start of the `snap` cycle. Increments in the `snap` cycle appear only in the live counters.
- `snap` and `clr` in the same cycle: shadow gets the pre-clear values, and live counters go to 0, so no event is lost.
- Out-of-range `rd_sel` (non-power-of-2 port count): all `rd_*` outputs read 0.

## Timing
- Reset values: all counters, shadows, `ovf`, `sop_d` = 0; all FSMs IDLE; `rd_*` = 0; `total_pkt_cnt` = 0; `in_pkt` = 0.
- Reset mid-packet forces IDLE and discards the partial packet; no error is counted.
- Event at cycle N: live counters and `in_pkt` update at N+1.
- `snap` at cycle N: shadows valid at N+1.
- `rd_*` are registered from the shadows: the value for `rd_sel` at cycle N appears at N+1.
- So `snap` at N with `rd_sel` steady shows the new value at N+2.
- `total_pkt_cnt` updates at N+1, the same cycle as the per-port counters; there is no extra pipeline stage.

## Test plan
- **Basic packet:** reset, then port 0 sends sop(1 cycle), 9 vld cycles, eop. Then snap, `rd_sel`=0 → pkt=1, word=10, err=0, `total_pkt_cnt`=1, `in_pkt[0]` high for exactly the packet duration.
- **All ports at once:** all 16 ports raise sop in the same cycle, 3 times → `total_pkt_cnt`=48 and every port pkt=3. This checks the popcount width.
- **Framing errors:** port 2 receives sop, sop, eop (missing eop), then a lone eop → pkt=2, err=2, FSM ends IDLE. Port 3 receives sop+eop in the same cycle → pkt=1, err=0, `in_pkt[3]` never 1.
- **Overflow, CNT_WIDTH=4:** 20 packets on port 1. SATURATE=1 → pkt=15, ovf=1. SATURATE=0 → pkt=4, ovf=1. After `clr` → pkt=0, ovf=0.
- **Snap/clr collision:** port 5 has pkt=7. Assert `snap` and `clr` together while a new sop rises in the same cycle → shadow pkt=7, live pkt=0.
- **Sticky sop and reset:** port 6 holds sop high for 50 cycles → pkt=1. `rst` at cycle 25 of a packet → next packet starts cleanly, err=0.
